// File: rtl/array_seq_pkg.sv
// Shared types for the array sequencer: playback modes and FSM states.
package array_seq_pkg;

   typedef enum logic [1:0] {
      WRAP     = 2'd0,
      ONESHOT  = 2'd1,
      PINGPONG = 2'd2,
      MODE_RSV = 2'd3
   } mode_e;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_e;

endpackage

// File: rtl/array_seq_if.sv
// Table-write and playback bus of the array sequencer.
interface array_seq_if #(
   parameter int N_CH  = 2,
   parameter int DEPTH = 8,
   parameter int WIDTH = 16
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = (N_CH > 1) ? $clog2(N_CH) : 1;

   logic                        wr_en;
   logic [CW-1:0]               wr_ch;
   logic [AW-1:0]               wr_addr;
   logic [WIDTH-1:0]            wr_data;
   logic                        start;
   logic                        stop;
   logic [1:0]                  mode;
   logic                        busy;
   logic                        done;
   logic [AW-1:0]               addr;
   logic                        valid;
   logic [N_CH-1:0][WIDTH-1:0]  data;

   modport master (
      output wr_en, wr_ch, wr_addr, wr_data, start, stop, mode,
      input  busy, done, addr, valid, data
   );

   modport slave (
      input  wr_en, wr_ch, wr_addr, wr_data, start, stop, mode,
      output busy, done, addr, valid, data
   );
endinterface

// File: rtl/array_bank.sv
// One channel's register-based table: single write port, registered read port.
module array_bank #(
   parameter int DEPTH = 8,
   parameter int WIDTH = 16,
   localparam int AW   = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             wr_en,
   input  logic [AW-1:0]    wr_addr,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             rd_en,
   input  logic [AW-1:0]    rd_addr,
   output logic [WIDTH-1:0] rd_data
);

   logic [DEPTH-1:0][WIDTH-1:0] mem_q, mem_d;
   logic [WIDTH-1:0]            rd_q, rd_d;

   // Read samples mem_q before this edge's write lands: read-before-write.
   always_comb begin
      mem_d = mem_q;
      if (wr_en) mem_d[wr_addr] = wr_data;
      rd_d = rd_en ? mem_q[rd_addr] : rd_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         mem_q <= '0;
         rd_q  <= '0;
      end else begin
         mem_q <= mem_d;
         rd_q  <= rd_d;
      end
   end

   assign rd_data = rd_q;

endmodule

// File: rtl/array_seq.sv
// Multi-channel table playback: one address sequencer (WRAP/ONESHOT/PINGPONG)
// driving N_CH parallel banks with one-cycle read latency.
module array_seq
   import array_seq_pkg::*;
#(
   parameter int N_CH  = 2,
   parameter int DEPTH = 8,
   parameter int WIDTH = 16
) (
   input logic        clk,
   input logic        rst,
   array_seq_if.slave bus
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = (N_CH > 1) ? $clog2(N_CH) : 1;
   localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

   state_e        state_q, state_d;
   mode_e         mode_q, mode_d;
   logic [AW-1:0] addr_q, addr_d;
   logic          dir_dn_q, dir_dn_d;
   logic          done_q, done_d;
   logic          valid_q, valid_d;

   always_comb begin
      state_d  = state_q;
      mode_d   = mode_q;
      addr_d   = addr_q;
      dir_dn_d = dir_dn_q;
      done_d   = 1'b0;
      valid_d  = (state_q == RUN);
      if (bus.stop) begin
         state_d = IDLE;
      end else if (bus.start) begin
         // Restart wins over ONESHOT completion, so no done here.
         state_d  = RUN;
         mode_d   = mode_e'(bus.mode);
         addr_d   = '0;
         dir_dn_d = 1'b0;
      end else if (state_q == RUN) begin
         case (mode_q)
            WRAP: addr_d = addr_q + AW'(1);
            PINGPONG: begin
               if (!dir_dn_q) begin
                  if (addr_q == LAST) begin
                     dir_dn_d = 1'b1;
                     addr_d   = addr_q - AW'(1);
                  end else begin
                     addr_d = addr_q + AW'(1);
                  end
               end else begin
                  if (addr_q == '0) begin
                     dir_dn_d = 1'b0;
                     addr_d   = AW'(1);
                  end else begin
                     addr_d = addr_q - AW'(1);
                  end
               end
            end
            default: begin
               if (addr_q == LAST) begin
                  state_d = IDLE;
                  done_d  = 1'b1;
               end else begin
                  addr_d = addr_q + AW'(1);
               end
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         mode_q   <= WRAP;
         addr_q   <= '0;
         dir_dn_q <= 1'b0;
         done_q   <= 1'b0;
         valid_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         mode_q   <= mode_d;
         addr_q   <= addr_d;
         dir_dn_q <= dir_dn_d;
         done_q   <= done_d;
         valid_q  <= valid_d;
      end
   end

   logic [N_CH-1:0][WIDTH-1:0] rd_data;

   for (genvar c = 0; c < N_CH; c++) begin : g_bank
      array_bank #(.DEPTH(DEPTH), .WIDTH(WIDTH)) u_bank (
         .clk     (clk),
         .rst     (rst),
         .wr_en   (bus.wr_en && (bus.wr_ch == CW'(c))),
         .wr_addr (bus.wr_addr),
         .wr_data (bus.wr_data),
         .rd_en   (state_q == RUN),
         .rd_addr (addr_q),
         .rd_data (rd_data[c])
      );
   end

   assign bus.busy  = (state_q == RUN);
   assign bus.done  = done_q;
   assign bus.addr  = addr_q;
   assign bus.valid = valid_q;
   assign bus.data  = rd_data;

endmodule

// File: tb/tb_array_seq.sv
// Directed bench for array_seq, N_CH=2 DEPTH=4 WIDTH=16, Q8.8 table values.
module tb_array_seq;

   logic clk = 1'b0;
   logic rst;
   int   checks = 0;
   int   failures = 0;

   logic [15:0] tbl0 [4];
   logic [15:0] tbl1 [4];

   always #5 clk = ~clk;

   array_seq_if #(.N_CH(2), .DEPTH(4), .WIDTH(16)) bus ();

   array_seq #(.N_CH(2), .DEPTH(4), .WIDTH(16)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic write(input logic ch, input logic [1:0] a, input logic [15:0] d);
      bus.wr_en = 1'b1; bus.wr_ch = ch; bus.wr_addr = a; bus.wr_data = d;
      tick();
      bus.wr_en = 1'b0;
   endtask

   task automatic test_reset();
      // Write and start during reset must be overridden.
      rst = 1'b1; bus.start = 1'b1; bus.wr_en = 1'b1;
      bus.wr_ch = 1'b0; bus.wr_addr = 2'd0; bus.wr_data = 16'h1234;
      tick();
      rst = 1'b0; bus.start = 1'b0; bus.wr_en = 1'b0;
      checks++;
      if ({bus.busy, bus.valid, bus.done} !== 3'b000) begin
         failures++; $display("FAIL reset_flags: got %b exp 000", {bus.busy, bus.valid, bus.done});
      end
      checks++;
      if (bus.addr !== 2'd0) begin failures++; $display("FAIL reset_addr: got %0d exp 0", bus.addr); end
      checks++;
      if (bus.data !== 32'h0) begin failures++; $display("FAIL reset_data: got %h exp 0", bus.data); end
      bus.start = 1'b1; bus.mode = 2'd0;
      tick();
      bus.start = 1'b0;
      tick();
      checks++;
      if (bus.data[0] !== 16'h0000) begin
         failures++; $display("FAIL reset_wr_ignored: got %h exp 0000", bus.data[0]);
      end
      bus.stop = 1'b1; tick(); bus.stop = 1'b0; tick();
   endtask

   task automatic test_wrap();
      for (int i = 0; i < 4; i++) write(1'b0, 2'(i), tbl0[i]);
      for (int i = 0; i < 4; i++) write(1'b1, 2'(i), tbl1[i]);
      bus.start = 1'b1; bus.mode = 2'd0;
      tick();
      bus.start = 1'b0; bus.mode = 2'd1;  // ignored during RUN
      for (int k = 0; k < 10; k++) begin
         checks++;
         if (bus.addr !== 2'(k % 4) || bus.busy !== 1'b1) begin
            failures++; $display("FAIL wrap_addr k=%0d: got %0d/%b exp %0d/1", k, bus.addr, bus.busy, k % 4);
         end
         if (k >= 1) begin
            checks++;
            if (bus.data[0] !== tbl0[(k-1)%4] || bus.data[1] !== tbl1[(k-1)%4] || bus.valid !== 1'b1) begin
               failures++;
               $display("FAIL wrap_data k=%0d: got %h %h v%b exp %h %h v1", k, bus.data[0], bus.data[1],
                        bus.valid, tbl0[(k-1)%4], tbl1[(k-1)%4]);
            end
         end
         tick();
      end
      bus.stop = 1'b1; tick(); bus.stop = 1'b0;
      checks++;
      if (bus.busy !== 1'b0 || bus.addr !== 2'd2 || bus.data[0] !== tbl0[2]) begin
         failures++; $display("FAIL wrap_stop: got b%b a%0d d%h exp b0 a2 d%h", bus.busy, bus.addr, bus.data[0], tbl0[2]);
      end
      tick();
      checks++;
      if (bus.valid !== 1'b0 || bus.data[0] !== tbl0[2] || bus.addr !== 2'd2) begin
         failures++; $display("FAIL idle_hold: got v%b d%h a%0d exp v0 d%h a2", bus.valid, bus.data[0], bus.addr, tbl0[2]);
      end
   endtask

   task automatic test_oneshot();
      int vcnt = 0;
      bus.start = 1'b1; bus.mode = 2'd1;
      tick();
      bus.start = 1'b0;
      for (int k = 0; k < 4; k++) begin
         vcnt += int'(bus.valid);
         checks++;
         if (bus.addr !== 2'(k) || bus.busy !== 1'b1 || bus.done !== 1'b0) begin
            failures++; $display("FAIL oneshot_addr k=%0d: got a%0d b%b d%b exp a%0d b1 d0", k, bus.addr, bus.busy, bus.done, k);
         end
         tick();
      end
      vcnt += int'(bus.valid);
      checks++;
      if (bus.busy !== 1'b0 || bus.done !== 1'b1 || bus.addr !== 2'd3 || bus.data[1] !== tbl1[3]) begin
         failures++; $display("FAIL oneshot_end: got b%b dn%b a%0d d%h exp b0 dn1 a3 d%h", bus.busy, bus.done, bus.addr, bus.data[1], tbl1[3]);
      end
      tick();
      vcnt += int'(bus.valid);
      checks++;
      if (bus.done !== 1'b0) begin failures++; $display("FAIL oneshot_done_pulse: got %b exp 0", bus.done); end
      checks++;
      if (vcnt !== 4) begin failures++; $display("FAIL oneshot_valid_cnt: got %0d exp 4", vcnt); end
   endtask

   task automatic test_pingpong();
      logic [1:0] seq [9] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd2, 2'd1, 2'd0, 2'd1, 2'd2};
      bus.start = 1'b1; bus.mode = 2'd2;
      tick();
      bus.start = 1'b0;
      for (int k = 0; k < 9; k++) begin
         checks++;
         if (bus.addr !== seq[k]) begin
            failures++; $display("FAIL pp_addr k=%0d: got %0d exp %0d", k, bus.addr, seq[k]);
         end
         if (k >= 1) begin
            checks++;
            if (bus.data[1] !== tbl1[seq[k-1]]) begin
               failures++; $display("FAIL pp_data k=%0d: got %h exp %h", k, bus.data[1], tbl1[seq[k-1]]);
            end
         end
         if (k == 8) bus.stop = 1'b1;
         tick();
      end
      bus.stop = 1'b0;
      checks++;
      if (bus.busy !== 1'b0 || bus.addr !== 2'd2 || bus.done !== 1'b0) begin
         failures++; $display("FAIL pp_stop: got b%b a%0d dn%b exp b0 a2 dn0", bus.busy, bus.addr, bus.done);
      end
      tick();
   endtask

   task automatic test_rbw();
      bus.start = 1'b1; bus.mode = 2'd0;
      tick();
      bus.start = 1'b0;
      tick(); tick();
      checks++;
      if (bus.addr !== 2'd2) begin failures++; $display("FAIL rbw_setup: got %0d exp 2", bus.addr); end
      bus.wr_en = 1'b1; bus.wr_ch = 1'b0; bus.wr_addr = 2'd2; bus.wr_data = 16'h0780;
      tick();
      bus.wr_en = 1'b0;
      checks++;
      if (bus.data[0] !== 16'h0300) begin failures++; $display("FAIL rbw_old: got %h exp 0300", bus.data[0]); end
      tick(); tick(); tick(); tick();
      checks++;
      if (bus.data[0] !== 16'h0780 || bus.data[1] !== tbl1[2]) begin
         failures++; $display("FAIL rbw_new: got %h %h exp 0780 %h", bus.data[0], bus.data[1], tbl1[2]);
      end
      bus.stop = 1'b1; tick(); bus.stop = 1'b0; tick();
   endtask

   task automatic test_start_stop();
      bus.start = 1'b1; bus.stop = 1'b1; bus.mode = 2'd0;
      tick();
      bus.start = 1'b0; bus.stop = 1'b0;
      checks++;
      if (bus.busy !== 1'b0) begin failures++; $display("FAIL start_stop_idle: got busy %b exp 0", bus.busy); end
      tick();
      checks++;
      if (bus.valid !== 1'b0 || bus.busy !== 1'b0) begin
         failures++; $display("FAIL start_stop_valid: got v%b b%b exp v0 b0", bus.valid, bus.busy);
      end
   endtask

   task automatic test_restart();
      bus.start = 1'b1; bus.mode = 2'd1;
      tick();
      bus.start = 1'b0;
      tick(); tick();
      bus.start = 1'b1; bus.mode = 2'd0;
      tick();
      bus.start = 1'b0;
      for (int k = 0; k < 6; k++) begin
         checks++;
         if (bus.addr !== 2'(k % 4) || bus.done !== 1'b0 || bus.busy !== 1'b1) begin
            failures++; $display("FAIL restart k=%0d: got a%0d dn%b b%b exp a%0d dn0 b1", k, bus.addr, bus.done, bus.busy, k % 4);
         end
         tick();
      end
   endtask

   task automatic test_reset_mid();
      // Enters still running WRAP from test_restart.
      rst = 1'b1; tick(); rst = 1'b0;
      checks++;
      if ({bus.busy, bus.valid, bus.done} !== 3'b000 || bus.addr !== 2'd0 || bus.data !== 32'h0) begin
         failures++; $display("FAIL reset_mid: got b%b v%b dn%b a%0d d%h exp all zero", bus.busy, bus.valid, bus.done, bus.addr, bus.data);
      end
      bus.start = 1'b1; bus.mode = 2'd0;
      tick();
      bus.start = 1'b0;
      for (int k = 0; k < 5; k++) begin
         if (k >= 1) begin
            checks++;
            if (bus.data !== 32'h0 || bus.valid !== 1'b1) begin
               failures++; $display("FAIL reset_cleared k=%0d: got %h v%b exp 0 v1", k, bus.data, bus.valid);
            end
         end
         tick();
      end
      bus.stop = 1'b1; tick(); bus.stop = 1'b0;
   endtask

   initial begin
      tbl0 = '{16'h0100, 16'h0200, 16'h0300, 16'h0400};
      tbl1 = '{16'hFF00, 16'hFE00, 16'hFD00, 16'hFC00};
      rst = 1'b1;
      bus.wr_en = 1'b0; bus.wr_ch = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
      bus.start = 1'b0; bus.stop = 1'b0; bus.mode = 2'd0;
      tick();
      test_reset();
      test_wrap();
      test_oneshot();
      test_pingpong();
      test_rbw();
      test_start_stop();
      test_restart();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/array_seq.md
ARRAY_SEQ -- requirements
Module: array_seq

Interface
REQ-001 Parameter N_CH, default 2: number of independent data channels sharing one address sequencer.
REQ-002 Parameter DEPTH, default 8: entries per channel; power of two, 2..256; AW = clog2(DEPTH).
REQ-003 Parameter WIDTH, default 16: signed fixed-point word width per entry.
REQ-004 clk  in  1  sole clock; all logic on rising edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 wr_en  in  1  table write strobe.
REQ-007 wr_ch  in  clog2(N_CH) (min 1)  write channel select.
REQ-008 wr_addr  in  AW  write entry index.
REQ-009 wr_data  in  WIDTH  signed value written.
REQ-010 start  in  1  pulse: begin a playback run.
REQ-011 stop  in  1  pulse: abort a run.
REQ-012 mode  in  2  playback mode, sampled at start: 0 WRAP, 1 ONESHOT, 2 PINGPONG, 3 reserved (treated as ONESHOT).
REQ-013 busy  out  1  high while in RUN.
REQ-014 done  out  1  single-cycle pulse at ONESHOT completion.
REQ-015 addr  out  AW  current sequencer address.
REQ-016 valid  out  1  data qualifies; equals busy delayed one cycle.
REQ-017 data  out  N_CH x WIDTH  registered signed table outputs, one per channel.

Function
REQ-018 FSM states IDLE, RUN; IDLE->RUN on start; RUN->IDLE on stop, or ONESHOT after address DEPTH-1 is issued.
REQ-019 On IDLE->RUN, addr loads 0 and direction up; mode latched into internal register; mode input ignored during RUN.
REQ-020 WRAP: addr increments each RUN cycle, DEPTH-1 -> 0.
REQ-021 ONESHOT: addr 0..DEPTH-1 once; done pulses the cycle after addr=DEPTH-1 is issued, coincident with busy falling.
REQ-022 PINGPONG: 0,1..DEPTH-1,DEPTH-2..1,0,1..; endpoints issued once per turn (no repeat).
REQ-023 In IDLE, addr holds its last value; data holds its last value; valid low.
REQ-024 Read latency one cycle: data[c] in cycle n+1 = table[c][addr in cycle n], for all channels simultaneously.
REQ-025 Writes accepted in any state; take effect at the clock edge.
REQ-026 Same-cycle write and read of the same entry: read returns the old value (read-before-write).
REQ-027 start while in RUN restarts: addr 0, new mode latched, no done pulse.
REQ-028 start and stop same cycle: stop wins; FSM ends in IDLE.
REQ-029 wr_ch >= N_CH: write discarded.
REQ-030 No arithmetic on stored data; values pass bit-exact.

Reset
REQ-031 rst forces IDLE, addr=0, busy=0, valid=0, done=0, data all zero, latched mode WRAP, direction up.
REQ-032 rst clears every table entry to zero in the same cycle (register-based storage).
REQ-033 rst overrides all other inputs including wr_en and start in the same cycle.
REQ-034 rst asserted mid-run: next cycle outputs at reset values; no done pulse.

Structure
REQ-035 Package array_seq_pkg holds the mode enum (WRAP, ONESHOT, PINGPONG) and the state enum (IDLE, RUN).
REQ-036 Sub-module array_bank: one channel's DEPTH x WIDTH storage with write port and registered read; instantiated N_CH times via generate.
REQ-037 Sequencer FSM, address counter, direction flag and valid/done logic live in array_seq top.

Verification
REQ-038 N_CH=2, DEPTH=4: write ch0 {1.0,2.0,3.0,4.0}, ch1 {-1,-2,-3,-4}, start mode WRAP -> data[0] 1,2,3,4,1,... and data[1] negated, one cycle after addr.
REQ-039 ONESHOT, DEPTH=4 -> addr 0,1,2,3; busy low and done high one cycle after addr=3 issued; valid covers exactly 4 samples.
REQ-040 PINGPONG, DEPTH=4 -> addr sequence 0,1,2,3,2,1,0,1,2 ...; stop after 9 cycles -> busy low next cycle, addr held.
REQ-041 Write table[0][2]=7.5 in the cycle addr=2 while old value 3.0 -> data shows 3.0; next visit shows 7.5.
REQ-042 rst pulse mid WRAP run -> next cycle busy=0, valid=0, addr=0, data=0; re-run without writes reads all zeros.
REQ-043 start and stop same cycle from IDLE -> stays IDLE; start during ONESHOT at addr=2 -> addr 0 next cycle, no done.
